// File: rtl/ebrick_umi_regfile.sv
// UMI responder: terminates single-beat read/write/posted requests against a small register file.
// Optional error responses are enabled by defining EBRICK_REGFILE_ERR_RESP_EN.
module ebrick_umi_regfile #(
  parameter int unsigned CW   = 32,
  parameter int unsigned AW   = 64,
  parameter int unsigned DW   = 32,
  parameter int unsigned NREG = 16,
  parameter logic [63:0] BASE = 64'h0,
  parameter logic [31:0] ID   = 32'h0000_EB01
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          udev_valid,
  input  logic [CW-1:0] udev_cmd,
  input  logic [AW-1:0] udev_dstaddr,
  input  logic [AW-1:0] udev_srcaddr,
  input  logic [DW-1:0] udev_data,
  output logic          udev_ready,
  output logic          uhost_valid,
  output logic [CW-1:0] uhost_cmd,
  output logic [AW-1:0] uhost_dstaddr,
  output logic [AW-1:0] uhost_srcaddr,
  output logic [DW-1:0] uhost_data,
  input  logic          uhost_ready
);

  localparam int unsigned BYTES   = DW / 8;
  localparam int unsigned ALIGN_W = $clog2(BYTES);
  localparam int unsigned IDX_W   = $clog2(NREG);
  localparam int unsigned SPAN    = NREG * BYTES;

  localparam logic [4:0] REQ_READ   = 5'h01;
  localparam logic [4:0] REQ_WRITE  = 5'h03;
  localparam logic [4:0] REQ_POSTED = 5'h05;
  localparam logic [4:0] RESP_READ  = 5'h02;
  localparam logic [4:0] RESP_WRITE = 5'h04;

  typedef enum logic {EMPTY, FULL} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cmd_q, cmd_d;
  logic [AW-1:0]       dst_q, dst_d;
  logic [AW-1:0]       src_q, src_d;
  logic [DW-1:0]       data_q, data_d;
  logic [DW-1:0]       regs_q [NREG];
  logic [DW-1:0]       regs_d [NREG];

  logic                accept;
  logic [4:0]          opcode;
  logic [2:0]          size;
  logic [7:0]          len;
  logic [4:0]          hostid;
  logic                borrow;
  logic [AW-1:0]       off;
  logic                in_range;
  logic                supported;
  logic                ok;
  logic [IDX_W-1:0]    idx;
  logic                is_rd, is_wr, is_po;
  logic                wr_en;
  logic                resp_en;
  logic [4:0]          resp_op;
  logic [1:0]          resp_err;
  logic [DW-1:0]       resp_data;
  logic [CW-1:0]       resp_cmd;
  logic                unused_cmd;

  assign udev_ready    = (state_q == EMPTY) | uhost_ready;
  assign accept        = udev_valid & udev_ready;
  assign uhost_valid   = (state_q == FULL);
  assign uhost_cmd     = cmd_q;
  assign uhost_dstaddr = dst_q;
  assign uhost_srcaddr = src_q;
  assign uhost_data    = data_q;
  assign unused_cmd    = ^udev_cmd[26:16];

  // Request decode and response formation
  always_comb begin
    opcode         = udev_cmd[4:0];
    size           = udev_cmd[7:5];
    len            = udev_cmd[15:8];
    hostid         = udev_cmd[31:27];
    {borrow, off}  = {1'b0, udev_dstaddr} - {1'b0, AW'(BASE)};
    in_range       = !borrow && (off < AW'(SPAN)) && (off[ALIGN_W-1:0] == '0);
    supported      = (size == 3'(ALIGN_W)) && (len == 8'd0);
    ok             = in_range && supported;
    idx            = off[ALIGN_W +: IDX_W];
    is_rd          = (opcode == REQ_READ);
    is_wr          = (opcode == REQ_WRITE);
    is_po          = (opcode == REQ_POSTED);
    wr_en          = (is_wr || is_po) && ok && (idx != '0);

    resp_en        = is_rd || is_wr;
    resp_op        = is_rd ? RESP_READ : RESP_WRITE;
    resp_err       = 2'b00;
    resp_data      = '0;
    if (is_rd && ok) begin
      resp_data = (idx == '0) ? DW'(ID) : regs_q[idx];
    end
`ifdef EBRICK_REGFILE_ERR_RESP_EN
    if ((is_rd && !ok) || (is_wr && !wr_en)) begin
      resp_err = 2'b10;
    end
    if (!is_rd && !is_wr && !is_po) begin
      resp_en  = 1'b1;
      resp_op  = RESP_WRITE;
      resp_err = 2'b11;
    end
`endif

    resp_cmd        = '0;
    resp_cmd[4:0]   = resp_op;
    resp_cmd[7:5]   = size;
    resp_cmd[15:8]  = len;
    resp_cmd[22]    = 1'b1;
    resp_cmd[26:25] = resp_err;
    resp_cmd[31:27] = hostid;
  end

  // Register file update and one-entry output stage next state
  always_comb begin
    regs_d  = regs_q;
    state_d = state_q;
    cmd_d   = cmd_q;
    dst_d   = dst_q;
    src_d   = src_q;
    data_d  = data_q;
    if (accept && wr_en) begin
      regs_d[idx] = udev_data;
    end
    if (accept && resp_en) begin
      state_d = FULL;
      cmd_d   = resp_cmd;
      dst_d   = udev_srcaddr;
      src_d   = udev_dstaddr;
      data_d  = resp_data;
    end else if (uhost_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      cmd_q   <= '0;
      dst_q   <= '0;
      src_q   <= '0;
      data_q  <= '0;
      for (int i = 0; i < int'(NREG); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      dst_q   <= dst_d;
      src_q   <= src_d;
      data_q  <= data_d;
      regs_q  <= regs_d;
    end
  end

endmodule

// File: doc/ebrick_umi_regfile.md
# ebrick_umi_regfile

UMI responder endpoint that terminates single-beat read, write and posted-write requests against a small register file and returns UMI responses. It is the far end of the 4x4 crossbar's memory/monitor request links: requests arrive on `udev_*`, and responses leave on `uhost_*` back toward the crossbar's response inputs. It uses a one-entry output stage, so full throughput is one request per cycle when the response sink is always ready.

## Interface
- `CW`, 32, UMI command width
- `AW`, 64, UMI address width
- `DW`, 32, data width; register width; power of two, at least 32
- `NREG`, 16, number of registers; power of two, at least 2
- `BASE`, 64'h0, byte address of register 0; aligned to NREG*DW/8
- `ID`, 32'h0000_EB01, value of read-only register 0
- `clk`  in  1  clock; single clock domain
- `reset`  in  1  synchronous, active-high reset
- `udev_valid`  in  1  request valid
- `udev_cmd`  in  CW  request command
- `udev_dstaddr`  in  AW  request target address
- `udev_srcaddr`  in  AW  requester return address
- `udev_data`  in  DW  write data
- `udev_ready`  out  1  request accepted when high with `udev_valid`
- `uhost_valid`  out  1  response valid
- `uhost_cmd`  out  CW  response command
- `uhost_dstaddr`  out  AW  response destination; equals request srcaddr
- `uhost_srcaddr`  out  AW  response source; equals request dstaddr
- `uhost_data`  out  DW  read data; 0 for write responses
- `uhost_ready`  in  1  response consumed when high with `uhost_valid`

## Operation
- Command fields: opcode [4:0], size [7:5], len [15:8], eom [22], err [26:25], hostid [31:27].
- Request opcodes are REQ_READ 5'h01, REQ_WRITE 5'h03 and REQ_POSTED 5'h05. Response opcodes are RESP_READ 5'h02 and RESP_WRITE 5'h04.
- A request is supported when size equals log2(DW/8) and len equals 0.
- A request is in range when dstaddr >= BASE, the offset (dstaddr - BASE) is less than NREG*DW/8, and the offset is DW/8-aligned. The register index is offset / (DW/8).
- Register 0 is read-only and returns `ID`. Registers 1..NREG-1 are read/write and reset to 0.
- REQ_WRITE and REQ_POSTED, when in range, supported and index != 0: the register is updated at the accept edge.
- REQ_READ: data is sampled at the accept edge. A write accepted in an earlier cycle is visible to the read.
- REQ_WRITE produces RESP_WRITE. REQ_READ produces RESP_READ. REQ_POSTED produces no response.
- Response cmd fields:
  - opcode as above
  - size and len copied from the request
  - eom = 1
  - hostid copied from the request
  - err as defined in Configuration
  - all other bits 0
- Any other request opcode is consumed and dropped, unless the macro in Configuration is defined.
- Output-stage states:
  - EMPTY → FULL when a response-producing request is accepted.
  - FULL → EMPTY when `uhost_ready` is high and no new response-producing request is accepted in that cycle.
  - FULL → FULL when a response is consumed and a new response-producing request is accepted in the same cycle.

## Timing
- `udev_ready` = !`uhost_valid` | `uhost_ready` (combinational). It is 1 out of reset.
- Response latency is 1 cycle: `uhost_valid` rises on the edge that accepts the request.
- `uhost_*` payload is stable while `uhost_valid` is high and `uhost_ready` is low.
- Back-to-back operation: with `uhost_ready` held at 1, one request is accepted every cycle and one response is issued every cycle.
- Reset values: `uhost_valid` 0, `uhost_cmd` 0, `uhost_dstaddr` 0, `uhost_srcaddr` 0, `uhost_data` 0. The state is EMPTY.
- Reset asserted mid-transaction discards any pending response and clears the registers on the next edge. Requests presented during reset are not accepted and cause no register update, even though `udev_ready` is 1.

## Configuration
- `EBRICK_REGFILE_ERR_RESP_EN` defined: error responses are enabled.
  - Out-of-range or unsupported REQ_READ/REQ_WRITE, and writes to register 0, return err = 2'b10 (SLVERR).
  - Other request opcodes return RESP_WRITE with err = 2'b11 (DEVERR).
  - Data is 0 and no register changes.
- `EBRICK_REGFILE_ERR_RESP_EN` undefined: err is always 2'b00.
  - Bad reads return data 0.
  - Bad writes are ignored.
  - Other opcodes are dropped with no response.

## Test plan
- Reset, then REQ_WRITE 0xA5A5_0001 to BASE+4 with srcaddr 0x1000, uhost_ready=1. Required: RESP_WRITE one cycle later, dstaddr 0x1000, err 0. A following REQ_READ of BASE+4 returns 0xA5A5_0001.
- REQ_READ of BASE+0. Required: data = ID (0x0000_EB01). Then REQ_WRITE of 0x1234 to BASE+0 and a read of BASE+0 still returns 0x0000_EB01; the write response has err 2'b10 with the macro defined, 0 without.
- Hold uhost_ready=0 for 5 cycles with a response pending. Required: payload stable and udev_ready=0 for those cycles. Release uhost_ready with a new request presented; that request is accepted in the same cycle as the handoff.
- Issue 8 back-to-back REQ_POSTED writes to registers 1..8, then read all 8 back with uhost_ready=1. Required: no posted responses, and the 8 read responses arrive on consecutive cycles with the correct data.
- REQ_READ of BASE+NREG*4 (out of range) and a REQ_WRITE with len=1. Required: SLVERR with the macro defined; without it, the read returns 0 with err 0 and the write gets an OK response with no register changed.
- Assert reset for 1 cycle while a response is pending and valid is held. Required: uhost_valid=0 and all registers 1..NREG-1 read back 0 afterward.
